pixel_line_buffer: RTL and testbench
====================================

PIXEL_LINE_BUFFER -- requirements
Module: pixel_line_buffer

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, giving the number of visible pixels per line.
REQ-002 SHALL provide parameter COLOR_W, default 12, giving the pixel width as 4:4:4 RGB.
REQ-003 SHALL have port CLK25MHZ, input, 1 bit: the single pixel clock; all logic is on its rising edge.
REQ-004 SHALL have port ck_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wr_data, input, COLOR_W bits: the pixel from the upstream renderer.
REQ-006 SHALL have port wr_valid, input, 1 bit: wr_data is valid.
REQ-007 SHALL have port wr_last, input, 1 bit: the current write is the last pixel of the line.
REQ-008 SHALL have port wr_ready, output, 1 bit: the buffer accepts a write this cycle.
REQ-009 SHALL have port pix_en, input, 1 bit: the display stage is in the active region and consumes one pixel per cycle.
REQ-010 SHALL have port next_line, input, 1 bit: a one-cycle pulse from the display stage at the end of each line.
REQ-011 SHALL have port color_out, output, COLOR_W bits: the pixel to the display stage's color_in.
REQ-012 SHALL have port line_ready, output, 1 bit: the read bank holds a complete line.
REQ-013 SHALL have port underrun, output, 1 bit: a sticky flag set when a pixel is requested from a bank that is not full.

Function
REQ-014 SHALL hold two banks of H_ACTIVE x COLOR_W storage, with per-bank state full[b] and length len[b] (range 1..H_ACTIVE).
REQ-015 SHALL use write-bank pointer wb and write address wa; a write is accepted when wr_valid && wr_ready.
REQ-016 SHALL drive wr_ready = !full[wb] combinationally.
REQ-017 SHALL run a write FSM with two states:
- W_FILL: wr_ready=1.
- W_STALL: entered when full[wb]=1; wr_ready=0.
REQ-018 SHALL, on each accepted write, store wr_data at bank wb, address wa, and increment wa.
REQ-019 SHALL close a line on an accepted write with wr_last=1 or wa=H_ACTIVE-1: set full[wb], set len[wb]=wa+1, toggle wb, clear wa.
REQ-020 SHALL ignore wr_last asserted without wr_valid.
REQ-021 SHALL use read-bank pointer rb and read address ra, and drive line_ready = full[rb].
REQ-022 SHALL run a read FSM with two states:
- R_WAIT: full[rb]=0.
- R_ACTIVE: full[rb]=1.
REQ-023 SHALL register color_out with exactly 1-cycle latency: if pix_en && full[rb] && ra<len[rb], color_out <= bank[rb][ra] and ra increments; otherwise color_out <= 0.
REQ-024 SHALL hold ra at len[rb] once reached, so that further pix_en cycles output 0 (a short line padded with black).
REQ-025 SHALL, on next_line with full[rb]=1, clear full[rb], toggle rb, and clear ra in the same cycle.
REQ-026 SHALL, on next_line with full[rb]=0, leave rb unchanged and clear ra.
REQ-027 SHALL set underrun (sticky) when pix_en=1 && full[rb]=0; only reset clears it.
REQ-028 SHALL update per-bank state independently when a write closes a line and next_line releases a bank in the same cycle; both updates take effect.
REQ-029 SHALL, when next_line releases bank b in the cycle wr_ready is 0 on bank b, assert wr_ready in the following cycle.
REQ-030 SHALL never let read and write address the same full bank: writes target only banks with full=0.

Reset
REQ-031 SHALL, while ck_rst=0, asynchronously force: full[1:0]=0, len=0, wb=0, rb=0, wa=0, ra=0, color_out=0, underrun=0, line_ready=0.
REQ-032 SHALL drive wr_ready=1 from the first cycle after reset release.
REQ-033 SHALL not clear or initialise bank contents on reset.
REQ-034 SHALL discard a partly written line and any line in progress on a mid-operation reset.

Verification
REQ-035 Fill line: write 640 pixels of value i[11:0] -> line_ready=1 after the 640th accept; wb=1; pix_en for 640 cycles gives color_out 0..639, each one cycle after its pix_en.
REQ-036 Short line: write 3 pixels 0xF00, 0x0F0, 0x00F with wr_last on the 3rd -> 5 pix_en cycles output F00, 0F0, 00F, 000, 000.
REQ-037 Backpressure: fill both banks -> wr_ready=0 and writes are ignored; next_line -> wr_ready=1 on the next cycle; rb=1.
REQ-038 Underrun: after reset, pix_en=1 with no writes -> color_out=0 and underrun=1, staying 1 after pix_en drops.
REQ-039 Simultaneous: the last write of bank 1 and next_line releasing bank 0 in the same cycle -> full=2'b10, rb=1, line_ready=1.
REQ-040 Reset mid-line: assert ck_rst=0 after 100 writes -> wr_ready=1, line_ready=0, color_out=0 immediately; the next write lands in bank 0, address 0.

Source files
------------

// File: rtl/pixel_line_buffer.sv
// Two-bank ping-pong line buffer between a pixel renderer and a display stage.
// The writer fills one bank while the display drains the other, one pixel per clock.
module pixel_line_buffer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned COLOR_W  = 12
) (
  input  logic               CLK25MHZ,
  input  logic               ck_rst,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               wr_valid,
  input  logic               wr_last,
  output logic               wr_ready,
  input  logic               pix_en,
  input  logic               next_line,
  output logic [COLOR_W-1:0] color_out,
  output logic               line_ready,
  output logic               underrun
);

  localparam int unsigned AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LW = $clog2(H_ACTIVE + 1);

  typedef enum logic {WFill, WStall} w_state_e;
  typedef enum logic {RWait, RActive} r_state_e;

  logic [COLOR_W-1:0] mem [2][H_ACTIVE];

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][LW-1:0] len_q, len_d;
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [AW-1:0]     wa_q, wa_d;
  logic [LW-1:0]     ra_q, ra_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic              underrun_q, underrun_d;

  logic wr_fire, wr_close, rd_fire;
  logic [COLOR_W-1:0] rd_pix;

  // The FSM states mirror full[wb] / full[rb] one-for-one, so the outputs decode them.
  assign wr_ready   = (w_state_q == WFill);
  assign line_ready = (r_state_q == RActive);
  assign color_out  = color_q;
  assign underrun   = underrun_q;

  assign wr_fire  = wr_valid && wr_ready;
  assign wr_close = wr_fire && (wr_last || (wa_q == AW'(H_ACTIVE - 1)));
  assign rd_fire  = pix_en && full_q[rb_q] && (ra_q < len_q[rb_q]);
  assign rd_pix   = mem[rb_q][ra_q[AW-1:0]];

  always_comb begin
    full_d     = full_q;
    len_d      = len_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    wa_d       = wa_q;
    ra_d       = ra_q;
    color_d    = '0;
    underrun_d = underrun_q | (pix_en && !full_q[rb_q]);

    if (wr_close) begin
      full_d[wb_q] = 1'b1;
      len_d[wb_q]  = LW'(wa_q) + LW'(1);
      wb_d         = ~wb_q;
      wa_d         = '0;
    end else if (wr_fire) begin
      wa_d = wa_q + AW'(1);
    end

    if (rd_fire) begin
      color_d = rd_pix;
    end

    // Writes only target empty banks, so a release never collides with a close.
    if (next_line) begin
      ra_d = '0;
      if (full_q[rb_q]) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end
    end else if (rd_fire) begin
      ra_d = ra_q + LW'(1);
    end

    w_state_d = full_d[wb_d] ? WStall : WFill;
    r_state_d = full_d[rb_d] ? RActive : RWait;
  end

  always_ff @(posedge CLK25MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      w_state_q  <= WFill;
      r_state_q  <= RWait;
      full_q     <= '0;
      len_q      <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wa_q       <= '0;
      ra_q       <= '0;
      color_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      full_q     <= full_d;
      len_q      <= len_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wa_q       <= wa_d;
      ra_q       <= ra_d;
      color_q    <= color_d;
      underrun_q <= underrun_d;
    end
  end

  // Pixel storage is deliberately left out of reset.
  always_ff @(posedge CLK25MHZ) begin
    if (wr_fire) begin
      mem[wb_q][wa_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_pixel_line_buffer.sv
// Directed self-checking bench for pixel_line_buffer with the default 640-pixel line.
module tb_pixel_line_buffer;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned COLOR_W  = 12;

  logic               clk;
  logic               rst_n;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_valid;
  logic               wr_last;
  logic               wr_ready;
  logic               pix_en;
  logic               next_line;
  logic [COLOR_W-1:0] color_out;
  logic               line_ready;
  logic               underrun;

  int tests_run;
  int tests_failed;

  pixel_line_buffer #(
    .H_ACTIVE(H_ACTIVE),
    .COLOR_W (COLOR_W)
  ) dut (
    .CLK25MHZ  (clk),
    .ck_rst    (rst_n),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .pix_en    (pix_en),
    .next_line (next_line),
    .color_out (color_out),
    .line_ready(line_ready),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set before the call; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    wr_last   = 1'b0;
    pix_en    = 1'b0;
    next_line = 1'b0;
  endtask

  task automatic write_px(input logic [COLOR_W-1:0] d, input logic last);
    wr_data  = d;
    wr_valid = 1'b1;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [COLOR_W-1:0] short_exp [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    wr_data      = '0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_line_ready", line_ready, 0);
    check("rst_color", color_out, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    #1;

    // Underrun: pixel requested with nothing buffered
    pix_en = 1'b1;
    tick();
    check("ur_color", color_out, 0);
    check("ur_flag", underrun, 1);
    pix_en = 1'b0;
    tick();
    tick();
    check("ur_sticky", underrun, 1);
    do_reset();
    check("ur_cleared", underrun, 0);

    // Full 640-pixel line
    for (int i = 0; i < H_ACTIVE; i++) begin
      write_px(COLOR_W'(i), 1'b0);
      if (i == H_ACTIVE - 2) check("fill_not_ready_639", line_ready, 0);
    end
    check("fill_line_ready", line_ready, 1);
    check("fill_wb", dut.wb_q, 1);
    check("fill_wr_ready", wr_ready, 1);
    pix_en = 1'b1;
    for (int i = 0; i < H_ACTIVE; i++) begin
      tick();
      check($sformatf("fill_px%0d", i), color_out, i);
    end
    tick();
    check("fill_past_end", color_out, 0);
    check("fill_no_underrun", underrun, 0);
    pix_en    = 1'b0;
    next_line = 1'b1;
    tick();
    next_line = 1'b0;
    check("fill_rel_line_ready", line_ready, 0);
    check("fill_rel_rb", dut.rb_q, 1);

    // Short line padded with black
    write_px(12'hF00, 1'b0);
    write_px(12'h0F0, 1'b0);
    write_px(12'h00F, 1'b1);
    check("short_line_ready", line_ready, 1);
    check("short_len", dut.len_q[1], 3);
    short_exp[0] = 12'hF00;
    short_exp[1] = 12'h0F0;
    short_exp[2] = 12'h00F;
    short_exp[3] = 12'h000;
    short_exp[4] = 12'h000;
    pix_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("short_px%0d", i), color_out, short_exp[i]);
    end
    pix_en    = 1'b0;
    next_line = 1'b1;
    tick();
    next_line = 1'b0;
    check("short_rel_rb", dut.rb_q, 0);

    // wr_last without wr_valid is ignored
    wr_last = 1'b1;
    tick();
    wr_last = 1'b0;
    check("last_no_valid_full", dut.full_q, 0);

    // Backpressure with both banks full
    write_px(12'h101, 1'b0);
    write_px(12'h102, 1'b1);
    write_px(12'h111, 1'b0);
    write_px(12'h222, 1'b1);
    check("bp_wr_ready", wr_ready, 0);
    check("bp_full", dut.full_q, 2'b11);
    write_px(12'hABC, 1'b0);
    check("bp_ignored_wa", dut.wa_q, 0);
    check("bp_still_stalled", wr_ready, 0);
    next_line = 1'b1;
    tick();
    next_line = 1'b0;
    check("bp_release_ready", wr_ready, 1);
    check("bp_release_rb", dut.rb_q, 1);
    check("bp_release_full", dut.full_q, 2'b10);
    pix_en = 1'b1;
    tick();
    check("bp_px0", color_out, 12'h111);
    tick();
    check("bp_px1", color_out, 12'h222);
    pix_en    = 1'b0;
    next_line = 1'b1;
    tick();
    next_line = 1'b0;
    check("bp_rel2_rb", dut.rb_q, 0);

    // Line close and bank release in the same cycle
    write_px(12'h0A1, 1'b0);
    write_px(12'h0A2, 1'b1);
    write_px(12'h0B1, 1'b0);
    next_line = 1'b1;
    write_px(12'h0B2, 1'b1);
    next_line = 1'b0;
    check("sim_full", dut.full_q, 2'b10);
    check("sim_rb", dut.rb_q, 1);
    check("sim_line_ready", line_ready, 1);
    check("sim_wr_ready", wr_ready, 1);
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    check("sim_px0", color_out, 12'h0B1);

    // Reset in the middle of a line
    for (int i = 0; i < 100; i++) write_px(COLOR_W'(12'h300 + i), 1'b0);
    check("mid_wa", dut.wa_q, 100);
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    check("mid_pre_color", color_out, 12'h0B2);
    check("mid_pre_line_ready", line_ready, 1);
    check("mid_no_underrun", underrun, 0);
    #5;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_ready", wr_ready, 1);
    check("mid_rst_line_ready", line_ready, 0);
    check("mid_rst_color", color_out, 0);
    check("mid_rst_full", dut.full_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    write_px(12'h5A5, 1'b1);
    check("post_rst_full", dut.full_q, 2'b01);
    check("post_rst_len", dut.len_q[0], 1);
    pix_en = 1'b1;
    tick();
    check("post_rst_px", color_out, 12'h5A5);
    tick();
    check("post_rst_pad", color_out, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
